apb_axi_lite_bridge: RTL and testbench

//  APB completer -> AXI4-Lite manager bridge: the reverse of our AXI4-Lite->APB bridge.

---
 rtl/apb_axi_lite_bridge_pkg.sv | 24 ++
 rtl/apb_axi_lite_bridge.sv | 197 +++++++++++++++++++
 tb/tb_apb_axi_lite_bridge.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_axi_lite_bridge_pkg.sv
// Shared types and constants for the APB -> AXI4-Lite bridge.
package apb_axi_lite_bridge_pkg;

    // Bridge FSM; one transaction in flight at a time.
    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StDone
    } state_e;

    // AXI response codes; bit 1 set means SLVERR or DECERR.
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExOkay = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/apb_axi_lite_bridge.sv
// APB completer to AXI4-Lite manager bridge. Each APB transfer becomes one single-beat AXI
// read or write; the APB access phase is stalled until the AXI response arrives.
module apb_axi_lite_bridge
    import apb_axi_lite_bridge_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] WINDOW_BYTES = 32'h0001_0000
) (
    input  logic              s_apb_pclk,
    input  logic              s_apb_preset,
    input  logic [ADDR_W-1:0] s_apb_paddr,
    input  logic              s_apb_psel,
    input  logic              s_apb_penable,
    input  logic              s_apb_pwrite,
    input  logic [31:0]       s_apb_pwdata,
    input  logic [3:0]        s_apb_pstrb,
    input  logic [2:0]        s_apb_pprot,
    output logic [31:0]       s_apb_prdata,
    output logic              s_apb_pready,
    output logic              s_apb_pslverr,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic [2:0]        prot_q, prot_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [31:0]       prdata_q, prdata_d;

    logic [ADDR_W-1:0] offset;
    logic              in_window;
    logic              setup;
    logic              aw_done, w_done;
    logic              unused_bits;

    // Unsigned offset compare handles address wrap around the top of the space.
    assign offset      = s_apb_paddr - BASE_ADDR;
    assign in_window   = offset < WINDOW_BYTES;
    assign setup       = s_apb_psel && !s_apb_penable;
    assign aw_done     = !awvalid_q || m_axi_awready;
    assign w_done      = !wvalid_q || m_axi_wready;
    assign unused_bits = ^{s_apb_paddr[1:0], m_axi_bresp[0], m_axi_rresp[0]};

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prot_d    = prot_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    addr_d  = {s_apb_paddr[ADDR_W-1:2], 2'b00};
                    wdata_d = s_apb_pwdata;
                    strb_d  = s_apb_pwrite ? s_apb_pstrb : 4'h0;
                    prot_d  = s_apb_pprot;
                    if (!in_window) begin
                        state_d   = StDone;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else if (s_apb_pwrite) begin
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrReq: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (m_axi_bvalid) begin
                    state_d   = StDone;
                    bready_d  = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = resp_is_err(m_axi_bresp);
                end
            end
            StRdReq: begin
                if (m_axi_arready) begin
                    state_d   = StRdResp;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdResp: begin
                if (m_axi_rvalid) begin
                    state_d   = StDone;
                    rready_d  = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = resp_is_err(m_axi_rresp);
                    prdata_d  = resp_is_err(m_axi_rresp) ? 32'h0 : m_axi_rdata;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge s_apb_pclk) begin
        if (s_apb_preset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prot_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prot_q    <= prot_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign s_apb_prdata  = prdata_q;
    assign s_apb_pready  = pready_q;
    assign s_apb_pslverr = pslverr_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = prot_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = strb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = prot_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_apb_axi_lite_bridge.sv
// Directed bench for the APB -> AXI4-Lite bridge. Inputs change and outputs are sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_apb_axi_lite_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_axi_lite_bridge dut (
        .s_apb_pclk    (clk),
        .s_apb_preset  (rst),
        .s_apb_paddr   (paddr),
        .s_apb_psel    (psel),
        .s_apb_penable (penable),
        .s_apb_pwrite  (pwrite),
        .s_apb_pwdata  (pwdata),
        .s_apb_pstrb   (pstrb),
        .s_apb_pprot   (pprot),
        .s_apb_prdata  (prdata),
        .s_apb_pready  (pready),
        .s_apb_pslverr (pslverr),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic setup(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        pstrb   = s;
        pprot   = p;
        psel    = 1'b1;
        penable = 1'b0;
    endtask

    task automatic apb_idle();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    function automatic logic any_out();
        return |{prdata, pready, pslverr, awaddr, awprot, awvalid, wdata, wstrb, wvalid,
                 bready, araddr, arprot, arvalid, rready};
    endfunction

    initial begin
        rst = 1'b1;
        paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pwdata = '0; pstrb = '0; pprot = '0;
        awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
        arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
        cyc();
        cyc();
        chk("reset_outputs_zero", 32'(any_out()), 0);
        rst = 1'b0;

        // Write, zero-wait slave: AW/W at T1, bready at T2, pready at T3 only.
        cyc();
        setup(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000);
        awready = 1'b1; wready = 1'b1;
        cyc();  // T1
        penable = 1'b1;
        chk("w1_awvalid_t1", 32'(awvalid), 1);
        chk("w1_wvalid_t1", 32'(wvalid), 1);
        chk("w1_awaddr", awaddr, 32'h10);
        chk("w1_wdata", wdata, 32'hDEAD_BEEF);
        chk("w1_wstrb", 32'(wstrb), 32'hF);
        chk("w1_pready_t1", 32'(pready), 0);
        cyc();  // T2
        chk("w1_bready_t2", 32'(bready), 1);
        chk("w1_awvalid_t2", 32'(awvalid), 0);
        chk("w1_wvalid_t2", 32'(wvalid), 0);
        chk("w1_pready_t2", 32'(pready), 0);
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        cyc();  // T3
        chk("w1_pready_t3", 32'(pready), 1);
        chk("w1_pslverr_t3", 32'(pslverr), 0);
        chk("w1_prdata_t3", prdata, 0);
        chk("w1_bready_t3", 32'(bready), 0);
        bvalid = 1'b0;
        apb_idle();
        cyc();  // T4
        chk("w1_pready_t4", 32'(pready), 0);

        // Read 0x24, arready low for three cycles.
        setup(32'h24, 1'b0, 32'h0, 4'hF, 3'b010);
        cyc();  // T1
        penable = 1'b1;
        chk("r1_arvalid_t1", 32'(arvalid), 1);
        chk("r1_araddr", araddr, 32'h24);
        chk("r1_arprot", 32'(arprot), 32'h2);
        cyc();  // T2
        chk("r1_arvalid_t2", 32'(arvalid), 1);
        cyc();  // T3
        chk("r1_arvalid_t3", 32'(arvalid), 1);
        cyc();  // T4
        chk("r1_arvalid_t4", 32'(arvalid), 1);
        chk("r1_rready_t4", 32'(rready), 0);
        arready = 1'b1;
        cyc();  // T5
        chk("r1_arvalid_t5", 32'(arvalid), 0);
        chk("r1_rready_t5", 32'(rready), 1);
        chk("r1_pready_t5", 32'(pready), 0);
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        cyc();  // T6
        chk("r1_pready_t6", 32'(pready), 1);
        chk("r1_prdata", prdata, 32'h1234_5678);
        chk("r1_pslverr", 32'(pslverr), 0);
        chk("r1_rready_t6", 32'(rready), 0);
        rvalid = 1'b0;
        apb_idle();
        cyc();  // T7
        chk("r1_pready_t7", 32'(pready), 0);
        chk("r1_prdata_t7", prdata, 0);

        // Write with awready at T1 but wready only at T4.
        setup(32'h40, 1'b1, 32'hCAFE_F00D, 4'h3, 3'b000);
        awready = 1'b1; wready = 1'b0;
        cyc();  // T1
        penable = 1'b1;
        chk("w2_awvalid_t1", 32'(awvalid), 1);
        chk("w2_wvalid_t1", 32'(wvalid), 1);
        cyc();  // T2
        awready = 1'b0;
        chk("w2_awvalid_t2", 32'(awvalid), 0);
        chk("w2_wvalid_t2", 32'(wvalid), 1);
        cyc();  // T3
        chk("w2_wvalid_t3", 32'(wvalid), 1);
        chk("w2_bready_t3", 32'(bready), 0);
        cyc();  // T4
        chk("w2_wvalid_t4", 32'(wvalid), 1);
        chk("w2_wstrb", 32'(wstrb), 32'h3);
        wready = 1'b1;
        cyc();  // T5
        wready = 1'b0;
        chk("w2_wvalid_t5", 32'(wvalid), 0);
        chk("w2_bready_t5", 32'(bready), 1);
        chk("w2_pready_t5", 32'(pready), 0);
        bvalid = 1'b1; bresp = 2'b00;
        cyc();  // T6
        chk("w2_pready_t6", 32'(pready), 1);
        chk("w2_pslverr_t6", 32'(pslverr), 0);
        bvalid = 1'b0;
        apb_idle();
        cyc();  // T7
        chk("w2_pready_t7", 32'(pready), 0);

        // Read returning DECERR, then back-to-back write returning SLVERR to an unaligned address.
        setup(32'h80, 1'b0, 32'h0, 4'h0, 3'b000);
        arready = 1'b1;
        cyc();  // T1
        penable = 1'b1;
        chk("r2_arvalid_t1", 32'(arvalid), 1);
        cyc();  // T2
        arready = 1'b0;
        chk("r2_rready_t2", 32'(rready), 1);
        rvalid = 1'b1; rdata = 32'hAAAA_5555; rresp = 2'b11;
        cyc();  // T3
        chk("r2_pready", 32'(pready), 1);
        chk("r2_pslverr_decerr", 32'(pslverr), 1);
        chk("r2_prdata_err_zero", prdata, 0);
        rvalid = 1'b0; rresp = 2'b00;
        apb_idle();
        cyc();  // T4, next setup
        chk("r2_pready_t4", 32'(pready), 0);
        setup(32'h107, 1'b1, 32'h1122_3344, 4'hF, 3'b000);
        awready = 1'b1; wready = 1'b1;
        cyc();  // T1
        penable = 1'b1;
        chk("w3_awaddr_aligned", awaddr, 32'h104);
        cyc();  // T2
        awready = 1'b0; wready = 1'b0;
        chk("w3_bready_t2", 32'(bready), 1);
        bvalid = 1'b1; bresp = 2'b10;
        cyc();  // T3
        chk("w3_pready", 32'(pready), 1);
        chk("w3_pslverr_slverr", 32'(pslverr), 1);
        chk("w3_prdata_zero", prdata, 0);
        bvalid = 1'b0; bresp = 2'b00;
        apb_idle();
        cyc();
        chk("w3_pready_after", 32'(pready), 0);

        // Address one past the window: error in the first access cycle, no AXI activity.
        setup(32'h0001_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b000);
        cyc();  // T1
        penable = 1'b1;
        chk("oow_pready_t1", 32'(pready), 1);
        chk("oow_pslverr_t1", 32'(pslverr), 1);
        chk("oow_no_valids_t1", 32'(awvalid | wvalid | arvalid), 0);
        apb_idle();
        cyc();  // T2
        chk("oow_pready_t2", 32'(pready), 0);
        chk("oow_no_valids_t2", 32'(awvalid | wvalid | arvalid), 0);

        // Reset while waiting for the write response, then a normal write.
        setup(32'h20, 1'b1, 32'h55AA_55AA, 4'hF, 3'b001);
        awready = 1'b1; wready = 1'b1;
        cyc();  // T1
        penable = 1'b1;
        chk("rs_awvalid_t1", 32'(awvalid), 1);
        cyc();  // T2
        awready = 1'b0; wready = 1'b0;
        chk("rs_bready_t2", 32'(bready), 1);
        rst = 1'b1;
        cyc();  // T3
        chk("rs_outputs_zero", 32'(any_out()), 0);
        rst = 1'b0;
        apb_idle();
        cyc();
        chk("rs_still_idle", 32'(any_out()), 0);
        setup(32'h30, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b000);
        awready = 1'b1; wready = 1'b1;
        cyc();  // T1
        penable = 1'b1;
        chk("rs_w_awvalid", 32'(awvalid), 1);
        chk("rs_w_awaddr", awaddr, 32'h30);
        cyc();  // T2
        awready = 1'b0; wready = 1'b0;
        chk("rs_w_bready", 32'(bready), 1);
        bvalid = 1'b1; bresp = 2'b00;
        cyc();  // T3
        chk("rs_w_pready", 32'(pready), 1);
        chk("rs_w_pslverr", 32'(pslverr), 0);
        bvalid = 1'b0;
        apb_idle();
        cyc();
        chk("rs_w_pready_after", 32'(pready), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
